// File: rtl/bus_responder.sv
// Target-side endpoint of the mreq/iorq bus: a mirrored word memory plus one
// output I/O port feeding a TX FIFO, with wait states and FIFO backpressure.
module bus_responder #(
  parameter int         DATA_WIDTH  = 8,
  parameter int         ADDR_WIDTH  = 16,
  parameter int         MEM_AW      = 10,
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] IO_PORT     = 8'h00,
  parameter int         FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iorq_n,
  input  logic                  mreq_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_n,
  input  logic                  wr_n,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  buswait_n,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    WAIT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [PW-1:0] ONE_P      = PW'(1);

  typedef logic [DATA_WIDTH-1:0] mem_t [MEM_DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < MEM_DEPTH; i++) m[i] = DATA_WIDTH'(i);
    return m;
  endfunction

  // Configuration-time contents; reset deliberately leaves them alone.
  mem_t mem_r = mem_init();

  logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [3:0]            wcnt_r;

  // Only a clean 0 asserts a strobe; X/Z on a floating line reads as idle.
  logic mreq_s, iorq_s, rd_s, wr_s;
  assign mreq_s = (mreq_n === 1'b0);
  assign iorq_s = (iorq_n === 1'b0);
  assign rd_s   = (rd_n === 1'b0);
  assign wr_s   = (wr_n === 1'b0);

  logic mem_rd_s, mem_wr_s, io_rd_s, io_wr_s, act_s, mapped_s, io_hit_s;
  assign mem_rd_s = mreq_s & ~iorq_s & rd_s & ~wr_s;
  assign mem_wr_s = mreq_s & ~iorq_s & ~rd_s & wr_s;
  assign io_rd_s  = iorq_s & ~mreq_s & rd_s & ~wr_s;
  assign io_wr_s  = iorq_s & ~mreq_s & ~rd_s & wr_s;
  assign act_s    = mem_rd_s | mem_wr_s | io_rd_s | io_wr_s;
  assign mapped_s = ~addr[ADDR_WIDTH-1];
  assign io_hit_s = (addr[7:0] == IO_PORT);

  logic unused_addr_s;
  assign unused_addr_s = ^addr[ADDR_WIDTH-2:MEM_AW];

  logic full_s, stall_s, done_s, push_s, pop_s;
  assign full_s  = (count_r == FULL_COUNT);
  assign stall_s = io_wr_s & io_hit_s & full_s;
  assign done_s  = act_s & (wcnt_r == 4'd0) & ~stall_s;
  assign push_s  = done_s & io_wr_s & io_hit_s;
  assign pop_s   = tx_valid & tx_ready;

  assign buswait_n = ~(reset_n & act_s & ((wcnt_r != 4'd0) | stall_s));
  assign tx_valid  = (count_r != {CW{1'b0}});
  assign tx_data   = tx_valid ? fifo_mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] rdata_s;

  // Read mux: memory, FIFO occupancy, or all-ones for anything unclaimed.
  always_comb begin
    rdata_s = {DATA_WIDTH{1'b1}};
    if (mem_rd_s && mapped_s) begin
      rdata_s = mem_r[addr[MEM_AW-1:0]];
    end else if (io_rd_s && io_hit_s) begin
      rdata_s = DATA_WIDTH'(count_r);
    end else begin
      rdata_s = {DATA_WIDTH{1'b1}};
    end
  end

  assign data = (reset_n & (mem_rd_s | io_rd_s)) ? rdata_s : {DATA_WIDTH{1'bz}};

  // Memory write lands only on the completion edge of a mapped write.
  always_ff @(posedge clk) begin
    if (reset_n && done_s && mem_wr_s && mapped_s) begin
      mem_r[addr[MEM_AW-1:0]] <= data;
    end
  end

  // FIFO storage is not reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (reset_n && push_s) begin
      fifo_mem_r[wr_ptr_r] <= data;
    end
  end

  // Wait counter reloads between accesses and on each completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wcnt_r <= WAIT_LOAD;
    end else if (!act_s || done_s) begin
      wcnt_r <= WAIT_LOAD;
    end else if (wcnt_r != 4'd0) begin
      wcnt_r <= wcnt_r - 4'd1;
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + ONE_P : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + ONE_P : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
